mdu_div: RTL
============

# mdu_div

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage, parallel to the ALU, and feeds the writeback result selector. Its output is one of the candidate `result` values. It accepts one operation at a time over a start/done handshake. Decode holds the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request; sampled only when `ready` is high.
- `kill`  in  1: synchronous abort of an operation in flight (pipeline flush).
- `op`  in  2: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0]).
- `dividend`  in  WIDTH: rs1 value, sampled with `start`.
- `divisor`  in  WIDTH: rs2 value, sampled with `start`.
- `ready`  out  1: high in IDLE and DONE.
- `busy`  out  1: high in CALC and FIX.
- `done`  out  1: single-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH: quotient or remainder; held after `done` until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Acceptance:
  - A start is accepted when `start` is high, `ready` is high and `kill` is low.
  - On acceptance, the operands, `op`, the signed flag (`op[0]==0`) and the result signs are latched.
  - Signed operands are converted to magnitudes.
- Special cases, resolved at acceptance with the next state DONE:
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed op with dividend == 100…0 and divisor == all ones (overflow): quotient = dividend; remainder = 0.
- Normal path: IDLE → CALC. The iteration counter loads WIDTH−1.
- CALC, one quotient bit per cycle:
  - Shift the {remainder, quotient} pair left by one.
  - Trial subtract the divisor magnitude; keep the difference if it is non-negative and set the quotient LSB to 1.
  - Arithmetic is WIDTH+1 bits wide so the borrow is explicit.
  - Counter reaches 0 → FIX.
- FIX, sign correction:
  - Quotient is negated if the signed op has dividend sign ≠ divisor sign.
  - Remainder takes the dividend's sign.
  - `op[1]` selects remainder, otherwise quotient, into `result`. Next state DONE.
- DONE:
  - `done` is high for this one cycle.
  - An accepted start here goes straight to CALC, or to DONE for a special case; otherwise the next state is IDLE.
- `start` while `busy` is high is ignored, with no queuing.
- `kill` high in CALC or FIX → IDLE on the next edge. `done` does not assert and `result` is unchanged. `kill` in IDLE or DONE blocks acceptance only.
- Reset (asynchronous, any state) → IDLE. Reset values: `result`=0, `done`=0, `busy`=0, `ready`=1, all internal registers 0.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Normal op accepted at edge N:
  - `busy` is high from N to N+WIDTH+1.
  - `done` is high in the cycle following edge N+WIDTH+1.
  - Latency is WIDTH+2 cycles; 34 for WIDTH=32.
- Special case accepted at edge N: `done` is high in the cycle after edge N (latency 1).
- Back-to-back throughput: accepting a start in DONE gives one op per WIDTH+2 cycles.

## Structure
- Shared package `rv_mdu_pkg`:
  - `mdu_op_t` (DIV, DIVU, REM, REMU encodings).
  - `div_state_t` enum.
  - Localparam `DIV_LAT = WIDTH+2` for hazard logic in decode.
- One natural sub-module, `div_step`: combinational shift, trial subtract and select for one iteration, parameterised on WIDTH. The top holds the FSM, counter, operand/sign registers and the FIX logic.

## Test plan
- DIVU 100/7 → `done` exactly 34 cycles after the start edge, `result`=14. REMU with the same operands → 2.
- DIV −100/7 → `result`=0xFFFFFFF2 (−14). REM −100/7 → `result`=0xFFFFFFFE (−2). REM 100/−7 → `result`=2.
- Divide by zero:
  - DIVU 5/0 → `result`=0xFFFFFFFF, `done` 1 cycle after acceptance.
  - REM 0x80000000/0 → `result`=0x80000000.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0. `done` 1 cycle after acceptance.
- Abort:
  - `kill` in CALC cycle 10 → IDLE next edge, `done` never pulses, `result` holds the prior value.
  - `start` while `busy` → ignored, original result unaffected.
- Reset and back-to-back:
  - `rst_n` low in CALC → all outputs at reset values immediately; after release, DIVU 9/3 → 3.
  - A start accepted in DONE → second `done` 34 cycles later.

Source files
------------

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// divider FSM states and the divider latency used by decode hazard logic.
package rv_mdu_pkg;

  localparam int XLEN    = 32;
  localparam int DIV_LAT = XLEN + 2;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;

  // Encoding matches funct3[1:0]: bit 0 clear means signed, bit 1 set means remainder.
  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial subtract the
// divisor magnitude and keep the difference when no borrow occurs.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The shifted partial remainder needs WIDTH+1 bits; diff[WIDTH] is the borrow.
  assign part   = {rem_in, quo_in[WIDTH-1]};
  assign diff   = part - {1'b0, dvs};
  assign borrow = diff[WIDTH];

  always_comb begin
    rem_out = part[WIDTH-1:0];
    if (!borrow) begin
      rem_out = diff[WIDTH-1:0];
    end
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a
// start/done handshake, pipeline-flush kill and single-cycle special cases.
module mdu_div
  import rv_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             sel_rem_reg;
  logic [WIDTH-1:0] result_reg;
  logic             done_reg;

  logic             accept;
  logic             is_signed;
  logic             is_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign ready  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign busy   = (state_reg == S_CALC) || (state_reg == S_FIX);
  assign done   = done_reg;
  assign result = result_reg;

  assign accept    = start && ready && !kill;
  assign is_signed = op_is_signed(mdu_op_t'(op));
  assign is_rem    = op_is_rem(mdu_op_t'(op));
  assign a_neg     = is_signed && dividend[WIDTH-1];
  assign b_neg     = is_signed && divisor[WIDTH-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);

  assign q_fix = q_neg_reg ? -quo_reg : quo_reg;
  assign r_fix = r_neg_reg ? -rem_reg : rem_reg;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_reg),
    .quo_in (quo_reg),
    .dvs    (dvs_reg),
    .rem_out(rem_next),
    .quo_out(quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      sel_rem_reg <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            sel_rem_reg <= is_rem;
            q_neg_reg   <= a_neg ^ b_neg;
            r_neg_reg   <= a_neg;
            if (div_zero) begin
              result_reg <= is_rem ? dividend : '1;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else if (overflow) begin
              result_reg <= is_rem ? '0 : dividend;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else begin
              rem_reg   <= '0;
              quo_reg   <= a_mag;
              dvs_reg   <= b_mag;
              cnt_reg   <= CW'(WIDTH - 1);
              state_reg <= S_CALC;
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_CALC: begin
          if (kill) begin
            state_reg <= S_IDLE;
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (cnt_reg == '0) begin
              state_reg <= S_FIX;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        S_FIX: begin
          if (kill) begin
            state_reg <= S_IDLE;
          end else begin
            result_reg <= sel_rem_reg ? r_fix : q_fix;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
